input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 20: clock cycles a raw input must hold steady before its debounced level changes.
REQ-002 Parameter GIRO_CYCLES, default 40: steady-hold cycles required for the tilt input.
REQ-003 Parameter WINDOW_CYCLES, default 100: idle cycles after the last test press before the test burst closes.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk in 1: single clock.
- rst in 1: synchronous, active-low reset.
- raw_sleep, raw_awake, raw_feed, raw_play, raw_test, raw_giro in 1 each: asynchronous raw pad inputs.
- botonSleep, botonAwake, botonFeed, botonPlay out 1 each: debounced levels.
- giro out 1: debounced tilt level.
- botonTest out 1: one-cycle strobe that closes a test burst.
- pulseTest out 4: test press count, valid while botonTest=1.

Function
REQ-005 Every raw input shall pass through a 2-flop synchronizer before any filtering (2 cycles of latency).
REQ-006 Debounce: a per-input counter shall increment while the synchronized input differs from the debounced output, and clear when they match.
- When the counter reaches DEB_CYCLES-1 (GIRO_CYCLES-1 for giro), the output toggles and the counter clears.
- Total latency from a clean raw edge to the output edge is 2+DEB_CYCLES cycles.
REQ-007 Glitches shorter than DEB_CYCLES cycles shall produce no output change.
REQ-008 The sleep, awake, feed and play outputs shall be levels, held for as long as the filtered input is held.
REQ-009 The test FSM shall have three states, IDLE, COUNT and EMIT, driven by the rising edge of the debounced test level (test_rise).
REQ-010 IDLE: on test_rise, go to COUNT, set cnt=1 and set the window timer to 0.
REQ-011 COUNT: on test_rise, cnt increments, saturating at 15, and the timer clears. Otherwise the timer increments.
REQ-012 COUNT: when the timer reaches WINDOW_CYCLES-1 with no test_rise in that cycle, go to EMIT.
REQ-013 If test_rise and the timer expiry fall in the same cycle, the press wins: increment cnt, clear the timer, stay in COUNT.
REQ-014 EMIT: botonTest=1 and pulseTest=cnt for exactly one cycle, then go to IDLE with cnt=0.
REQ-015 In EMIT, a test_rise is ignored. A new burst requires a fresh rising edge seen in IDLE.
REQ-016 pulseTest shall be 0 whenever botonTest=0.
REQ-017 The window timer shall be wide enough for WINDOW_CYCLES and shall never wrap.

Reset
REQ-018 While rst=0 at a clock edge, all of the following shall clear:
- synchronizers, debounce counters and all debounced outputs;
- botonTest, pulseTest and cnt;
- the timer, with the FSM returning to IDLE.
REQ-019 A reset asserted mid-burst, in COUNT or EMIT, shall discard the burst with no botonTest strobe.
REQ-020 After reset release, inputs already held high shall reach their outputs only after the full 2+DEB_CYCLES cycles.

Structure
REQ-021 A shared include file shall hold the FSM state encodings (IDLE=2'd0, COUNT=2'd1, EMIT=2'd2) and the default cycle constants.
REQ-022 A single sub-module, debounce, shall contain the synchronizer and counter with a parameter for cycle count. It shall be instantiated six times.
REQ-023 The test-burst FSM and edge detector shall live in input_conditioner itself.

Verification
REQ-024 Step test: raw_feed 0->1 held, with DEB_CYCLES=4 -> botonFeed rises exactly 6 cycles later and stays high while the input is held.
REQ-025 Glitch: raw_play high for 3 cycles, with DEB_CYCLES=4 -> botonPlay stays 0.
REQ-026 Burst: 5 clean test presses, each gap under WINDOW_CYCLES -> a single botonTest pulse with pulseTest=5, one cycle, WINDOW_CYCLES after the last press's debounced edge.
REQ-027 Saturation: 18 presses in one window -> pulseTest=15.
REQ-028 Reset mid-COUNT after 3 presses -> no botonTest. A following 2-press burst -> pulseTest=2.
REQ-029 Tilt: raw_giro bouncing for 30 cycles then steady high, with GIRO_CYCLES=40 -> giro rises once, 42 cycles after the last bounce.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// input_conditioner_pkg
// Shared definitions for the input conditioner slice:
//   - test_state_t : encodings of the test-burst FSM (IDLE/COUNT/EMIT)
//   - DEF_*_CYCLES : default debounce / tilt / window cycle counts
//   - sat_inc()    : saturating increment for the 4-bit press counter
// ----------------------------------------------------------------------------
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EMIT  = 2'd2
  } test_state_t;

  localparam int DEF_DEB_CYCLES    = 20;
  localparam int DEF_GIRO_CYCLES   = 40;
  localparam int DEF_WINDOW_CYCLES = 100;

  localparam int         PULSE_W = 4;
  localparam logic [3:0] CNT_MAX = 4'd15;

  // Press counter sticks at 15 instead of wrapping back to 0.
  function automatic logic [PULSE_W-1:0] sat_inc(input logic [PULSE_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/input_conditioner_debounce.sv
// ----------------------------------------------------------------------------
// debounce
// Two-flop synchronizer followed by a steady-hold counter. The output level
// toggles only after the synchronized input has disagreed with it for CYCLES
// consecutive clocks; any agreement in between restarts the count.
// Latency from a clean raw edge to the output edge: 2 + CYCLES clocks.
//
// Ports:
//   clk   in  : clock
//   rst   in  : synchronous, active-low reset
//   raw   in  : asynchronous pad input
//   level out : debounced level
// ----------------------------------------------------------------------------
module debounce
  import input_conditioner_pkg::*;
#(
  parameter int CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int             CW       = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // NOTE: reset is sampled on the clock edge only (synchronous); it is not in
  // the sensitivity list, so a reset pulse must span at least one rising edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let sync[1] take the old sync[0]
      // value, which is what makes this a two-stage shift register.
      sync <= {sync[0], raw};
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// ----------------------------------------------------------------------------
// input_conditioner
// Debounces six raw pad inputs and turns bursts of test presses into a single
// counted strobe.
//
// Ports:
//   clk, rst                        : clock, synchronous active-low reset
//   raw_sleep/awake/feed/play/test  : raw button pads (async)
//   raw_giro                        : raw tilt switch pad (async)
//   botonSleep/Awake/Feed/Play  out : debounced button levels
//   giro                        out : debounced tilt level (longer filter)
//   botonTest                   out : one-cycle strobe closing a test burst
//   pulseTest[3:0]              out : presses in the burst (0 unless strobe)
//
// Test burst: each rising edge of the debounced test level counts one press.
// The window timer restarts on every press; once it has run WINDOW_CYCLES
// cycles without a press the count is emitted for one cycle.
// ----------------------------------------------------------------------------
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int GIRO_CYCLES   = DEF_GIRO_CYCLES,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               raw_sleep,
  input  logic               raw_awake,
  input  logic               raw_feed,
  input  logic               raw_play,
  input  logic               raw_test,
  input  logic               raw_giro,
  output logic               botonSleep,
  output logic               botonAwake,
  output logic               botonFeed,
  output logic               botonPlay,
  output logic               giro,
  output logic               botonTest,
  output logic [PULSE_W-1:0] pulseTest
);

  // Timer must hold WINDOW_CYCLES-1; it leaves COUNT at that value, so it
  // can never wrap.
  localparam int            TW         = $clog2(WINDOW_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(WINDOW_CYCLES - 1);

  logic test_lvl;
  logic test_q;
  logic test_rise;

  debounce #(.CYCLES(DEB_CYCLES))  u_deb_sleep (.clk(clk), .rst(rst), .raw(raw_sleep), .level(botonSleep));
  debounce #(.CYCLES(DEB_CYCLES))  u_deb_awake (.clk(clk), .rst(rst), .raw(raw_awake), .level(botonAwake));
  debounce #(.CYCLES(DEB_CYCLES))  u_deb_feed  (.clk(clk), .rst(rst), .raw(raw_feed),  .level(botonFeed));
  debounce #(.CYCLES(DEB_CYCLES))  u_deb_play  (.clk(clk), .rst(rst), .raw(raw_play),  .level(botonPlay));
  debounce #(.CYCLES(DEB_CYCLES))  u_deb_test  (.clk(clk), .rst(rst), .raw(raw_test),  .level(test_lvl));
  debounce #(.CYCLES(GIRO_CYCLES)) u_deb_giro  (.clk(clk), .rst(rst), .raw(raw_giro),  .level(giro));

  assign test_rise = test_lvl & ~test_q;

  test_state_t          state;
  logic [PULSE_W-1:0]   cnt;
  logic [TW-1:0]        timer;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      timer     <= '0;
      test_q    <= 1'b0;
      botonTest <= 1'b0;
      pulseTest <= '0;
    end else begin
      test_q    <= test_lvl;
      // Strobe outputs default low; only the COUNT->EMIT transition raises them.
      botonTest <= 1'b0;
      pulseTest <= '0;
      case (state)
        IDLE: begin
          if (test_rise) begin
            state <= COUNT;
            cnt   <= 4'd1;
            timer <= '0;
          end
        end
        COUNT: begin
          // A press arriving on the expiry cycle keeps the burst open.
          if (test_rise) begin
            cnt   <= sat_inc(cnt);
            timer <= '0;
          end else if (timer == TIMER_LAST) begin
            state     <= EMIT;
            botonTest <= 1'b1;
            pulseTest <= cnt;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        EMIT: begin
          // Presses here are dropped; a new burst needs a rise seen in IDLE.
          state <= IDLE;
          cnt   <= '0;
          timer <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// ----------------------------------------------------------------------------
// tb_input_conditioner
// Table of debounced-level vectors, hand sequences for latency, glitch, tilt
// and reset corners, and a scoreboard of expected test strobes (count and
// exact cycle) compared by a monitor on every falling edge.
// ----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int DEB     = 4;
  localparam int GIRO    = 40;
  localparam int WIN     = 20;
  localparam int LAT     = DEB + 2;
  // raw press driven at cycle P -> strobe visible at cycle P + STB_LAT
  localparam int STB_LAT = DEB + 3 + WIN;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       raw_sleep = 1'b0, raw_awake = 1'b0, raw_feed = 1'b0;
  logic       raw_play = 1'b0, raw_test = 1'b0, raw_giro = 1'b0;
  logic       botonSleep, botonAwake, botonFeed, botonPlay, giro, botonTest;
  logic [3:0] pulseTest;

  input_conditioner #(
    .DEB_CYCLES(DEB), .GIRO_CYCLES(GIRO), .WINDOW_CYCLES(WIN)
  ) dut (
    .clk(clk), .rst(rst),
    .raw_sleep(raw_sleep), .raw_awake(raw_awake), .raw_feed(raw_feed),
    .raw_play(raw_play), .raw_test(raw_test), .raw_giro(raw_giro),
    .botonSleep(botonSleep), .botonAwake(botonAwake), .botonFeed(botonFeed),
    .botonPlay(botonPlay), .giro(giro), .botonTest(botonTest),
    .pulseTest(pulseTest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;
  int last_press = 0;

  typedef struct {
    int cnt;
    int cyc;
  } strobe_t;
  strobe_t sb[$];

  // {sleep, awake, feed, play, giro}
  typedef struct {
    logic [4:0] raw;
    int         hold;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [4:0] levels();
    return {botonSleep, botonAwake, botonFeed, botonPlay, giro};
  endfunction

  // Strobe monitor: every cycle botonTest must match the scoreboard head's
  // expected cycle, and pulseTest must be the count then and 0 otherwise.
  always @(negedge clk) begin
    logic exp_bt;
    int   exp_cnt;
    exp_bt  = (sb.size() > 0) && (sb[0].cyc == cyc);
    exp_cnt = exp_bt ? sb[0].cnt : 0;
    check("botonTest", 32'(botonTest), 32'(exp_bt));
    check("pulseTest", 32'(pulseTest), 32'(exp_cnt));
    if (exp_bt) void'(sb.pop_front());
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap();
    last_press = cyc;
    raw_test = 1'b1;
    wait_cyc(8);
    raw_test = 1'b0;
  endtask

  task automatic expect_strobe(input int n);
    strobe_t s;
    s.cnt = (n > 15) ? 15 : n;
    s.cyc = last_press + STB_LAT;
    sb.push_back(s);
  endtask

  task automatic burst(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      tap();
      if (k < n - 1) wait_cyc(gap - 8);
    end
    expect_strobe(n);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
    wait_cyc(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{5'b00000, 8,  5'b00000};
    vecs[1]  = '{5'b10000, 8,  5'b10000};
    vecs[2]  = '{5'b11000, 8,  5'b11000};
    vecs[3]  = '{5'b01100, 8,  5'b01100};
    vecs[4]  = '{5'b00110, 8,  5'b00110};
    vecs[5]  = '{5'b00000, 8,  5'b00000};
    vecs[6]  = '{5'b00010, 3,  5'b00000};  // 3-cycle play glitch
    vecs[7]  = '{5'b00000, 8,  5'b00000};
    vecs[8]  = '{5'b10101, 8,  5'b10100};  // giro not yet through its filter
    vecs[9]  = '{5'b10101, 40, 5'b10101};
    vecs[10] = '{5'b00000, 8,  5'b00001};  // giro still holds high
    vecs[11] = '{5'b00000, 40, 5'b00000};

    // Reset state
    wait_cyc(3);
    check("reset_levels", 32'(levels()), 32'd0);
    rst = 1'b1;

    // Table-driven debounced levels
    for (int i = 0; i < 12; i++) begin
      {raw_sleep, raw_awake, raw_feed, raw_play, raw_giro} = vecs[i].raw;
      wait_cyc(vecs[i].hold);
      check($sformatf("vec%0d", i), 32'(levels()), 32'(vecs[i].exp));
    end

    // Step: feed rises exactly 2+DEB cycles after the raw edge and holds
    raw_feed = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      wait_cyc(1);
      check("step_feed", 32'(botonFeed), 32'(k >= LAT));
    end
    raw_feed = 1'b0;
    wait_cyc(10);

    // Tilt: bounce for 30 cycles, then steady high
    for (int s = 0; s < 10; s++) begin
      raw_giro = (s % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        wait_cyc(1);
        check("giro_bounce", 32'(giro), 32'd0);
      end
    end
    raw_giro = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      wait_cyc(1);
      check("giro_rise", 32'(giro), 32'(k >= GIRO + 2));
    end
    raw_giro = 1'b0;
    wait_cyc(GIRO + 5);

    // Five-press burst
    burst(5, 16);
    drain();

    // Saturation at 15
    burst(18, 16);
    drain();

    // Press landing exactly on the expiry cycle extends the burst
    tap();
    wait_cyc(WIN - 8);
    tap();
    expect_strobe(2);
    drain();

    // Press landing in EMIT is ignored: one strobe of 1, none afterwards
    tap();
    expect_strobe(1);
    wait_cyc(WIN + 1 - 8);
    tap();
    drain();
    wait_cyc(WIN + DEB + 10);

    // Reset mid-COUNT discards the burst; held input re-qualifies fully
    raw_sleep = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tap();
      wait_cyc(8);
    end
    check("sleep_pre_reset", 32'(botonSleep), 32'd1);
    rst = 1'b0;
    wait_cyc(2);
    check("reset_mid_levels", 32'(levels()), 32'd0);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_cyc(1);
      check("sleep_post_reset", 32'(botonSleep), 32'(k >= LAT));
    end
    wait_cyc(WIN + 20);
    raw_sleep = 1'b0;
    burst(2, 16);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
